vigna_bus_arbiter: RTL and testbench
====================================

# vigna_bus_arbiter

Parametrised N-to-1 arbiter for the vigna valid/ready memory bus, successor to the fixed two-master merge used for a unified instruction/data port. It multiplexes `NUM_MASTERS` request ports (core I-port, core D-port, DMA, debug, ...) onto one slave port, one transaction at a time. It sits between vigna cores or peripherals and the single system memory/interconnect port.

## Interface
Parameters:
- `NUM_MASTERS`, 2, number of master ports (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `m_valid`  in  NUM_MASTERS  per-master request
- `m_ready`  out  NUM_MASTERS  per-master completion, one-hot or zero
- `m_addr`  in  NUM_MASTERS*ADDR_W  packed addresses, master i at bits [i*ADDR_W +: ADDR_W]
- `m_wdata`  in  NUM_MASTERS*DATA_W  packed write data
- `m_wstrb`  in  NUM_MASTERS*DATA_W/8  packed strobes; all-zero = read
- `m_rdata`  out  DATA_W  read data, broadcast to all masters, qualified by `m_ready[i]`
- `s_valid`  out  1  slave request
- `s_ready`  in  1  slave completion
- `s_addr`  out  ADDR_W  slave address
- `s_wdata`  out  DATA_W  slave write data
- `s_wstrb`  out  DATA_W/8  slave strobes
- `s_rdata`  in  DATA_W  slave read data

## Operation
- Bus protocol: master holds valid, addr, wdata, wstrb stable until the cycle its ready is high; ready for one cycle completes the transfer.
- FSM states: IDLE, BUSY.
- IDLE: if any `m_valid` set, winner chosen by arbitration, registered into `grant` (index, $clog2(NUM_MASTERS) bits), go to BUSY. No output asserted in IDLE.
- BUSY: `s_valid = m_valid[grant]`; `s_addr/s_wdata/s_wstrb` = granted master's fields; `m_rdata = s_rdata`; `m_ready[grant] = s_ready` combinationally, all other ready bits 0.
- BUSY and `s_ready`: return to IDLE; `last = grant`.
- BUSY and `m_valid[grant]` low (protocol violation / withdrawn request): return to IDLE, no ready, `last` unchanged.
- Arbitration: round-robin, search starts at `last+1` modulo NUM_MASTERS (see Configuration).
- Non-granted masters stall with ready low; their requests are never lost or reordered within a master.
- In IDLE `s_addr`, `s_wdata`, `s_wstrb` drive zero, `m_rdata` drives zero.

## Timing
- Reset values: state IDLE, `grant` 0, `last` NUM_MASTERS-1 (master 0 wins first), `s_valid` 0, `m_ready` 0, all slave data outputs 0.
- Arbitration latency: 1 cycle (request in cycle t in IDLE, `s_valid` in t+1).
- Slave zero-wait (`s_ready` same cycle as `s_valid`): `m_ready` in t+1, master sees 2-cycle transaction.
- Back-to-back: at least one IDLE cycle between grants; throughput 1 transfer per 2 cycles with zero-wait slave.
- Simultaneous requests: exactly one winner per IDLE cycle.
- Reset mid-BUSY: next cycle IDLE, all outputs at reset values, in-flight transfer dropped without `m_ready`.
- No combinational path from `m_valid` to `s_valid` in IDLE; path `s_ready` -> `m_ready` is combinational.

## Configuration
- `VIGNA_BUS_ARB_ROUND_ROBIN_EN` defined: round-robin as above, `last` register present.
- Undefined: fixed priority, lowest index wins; `last` register removed; master 0 can starve others.

## Structure
- Shared package `vigna_bus_pkg`: state encoding (IDLE/BUSY), default ADDR_W/DATA_W constants.
- Sub-module `vigna_rr_pick`: combinational picker, inputs request vector and start index, outputs winner index and `any` flag; fixed-priority mode ties start index to 0.

## Test plan
- NUM_MASTERS=3, single request m1 read addr 0x100, slave zero-wait rdata 0xDEADBEEF -> `s_valid` cycle t+1 with `s_addr`=0x100, `m_ready`=3'b010 same cycle, `m_rdata`=0xDEADBEEF.
- All three request continuously, round-robin -> grant order 0,1,2,0,1,2; each `m_ready` once per 6 cycles.
- Same stimulus, macro undefined, m0 re-requests immediately -> m0 served every transaction, m1/m2 never ready.
- m2 write addr 0x20 wdata 0x12345678 wstrb 4'b0011, slave 3 wait states -> slave fields stable 4 cycles, `m_ready[2]` only on 4th.
- Reset asserted during BUSY with slave stalled -> next cycle `s_valid`=0, `m_ready`=0; after release master 0 served first.
- Granted master drops valid before `s_ready` -> `s_valid` low that cycle, FSM IDLE next, other pending master granted following cycle.

Source files
------------

// File: rtl/vigna_bus_pkg.sv
// Shared definitions for the vigna bus arbiter: FSM state encoding, default
// bus widths and the grant-index width helper.
package vigna_bus_pkg;

  localparam int VIGNA_ADDR_W = 32;
  localparam int VIGNA_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Index width for n masters; never below one bit so n=1 stays legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vigna_rr_pick.sv
// Combinational picker: first asserted request at or after `start`, wrapping
// modulo NUM_MASTERS. A start of zero degenerates to lowest-index priority.
module vigna_rr_pick
  import vigna_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       start,
  output logic [IDX_W-1:0]       winner,
  output logic                   any
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0] pos;

  // NOTE: every output of an always_comb gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    pos    = '0;
    // Walk from the farthest offset back to the nearest so the nearest hit wins.
    for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
      pos = {1'b0, start} + PW'(off);
      if (pos >= PW'(NUM_MASTERS)) begin
        pos = pos - PW'(NUM_MASTERS);
      end
      if (req[pos[IDX_W-1:0]]) begin
        winner = pos[IDX_W-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vigna_bus_arbiter.sv
// N-to-1 arbiter for the vigna valid/ready bus, one transaction at a time.
// Define VIGNA_BUS_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module vigna_bus_arbiter
  import vigna_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = VIGNA_ADDR_W,
  parameter int DATA_W      = VIGNA_DATA_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_valid,
  output logic [NUM_MASTERS-1:0]          m_ready,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            s_valid,
  input  logic                            s_ready,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]               s_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = idx_width(NUM_MASTERS);

  arb_state_t       state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last;

  assign start = (last == IDX_W'(NUM_MASTERS - 1)) ? '0 : last + 1'b1;
`else
  assign start = '0;
`endif

  vigna_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_pick (
    .req    (m_valid),
    .start  (start),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= '0;
`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
      last  <= IDX_W'(NUM_MASTERS - 1);
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant <= pick_idx;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // A withdrawn request ends the grant without a completion.
          if (!m_valid[grant]) begin
            state <= ST_IDLE;
          end else if (s_ready) begin
            state <= ST_IDLE;
`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
            last  <= grant;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Slave side follows the granted master only while BUSY; IDLE drives zeros,
  // which keeps m_valid off the s_valid path during arbitration.
  always_comb begin
    s_valid = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_rdata = '0;
    m_ready = '0;
    if (state == ST_BUSY) begin
      s_valid        = m_valid[grant];
      s_addr         = m_addr[int'(grant) * ADDR_W +: ADDR_W];
      s_wdata        = m_wdata[int'(grant) * DATA_W +: DATA_W];
      s_wstrb        = m_wstrb[int'(grant) * STRB_W +: STRB_W];
      m_rdata        = s_rdata;
      m_ready[grant] = s_ready & m_valid[grant];
    end
  end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Self-checking bench for vigna_bus_arbiter with three masters; honours
// VIGNA_BUS_ARB_ROUND_ROBIN_EN the same way the design does.
`timescale 1ns/1ps
module tb_vigna_bus_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic          sv;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [N-1:0]  rdy;
    logic [DW-1:0] rdata;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  m_valid;
  logic [N-1:0]  m_ready;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0] m_rdata;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] s_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vigna_bus_arbiter #(
    .NUM_MASTERS (N),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata)
  );

  obs_t act;
  obs_t exp_o;
  assign act = {s_valid, s_addr, s_wdata, s_wstrb, m_ready, m_rdata};

  // Reference model: which master owns the bus, and who was served last.
  bit mdl_busy  = 1'b0;
  int mdl_grant = 0;
`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
  int mdl_last  = N - 1;
`endif

  function automatic int pick(input logic [N-1:0] req, input int start);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (req[idx] === 1'b1) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model_seq
    int w;
`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
    w = pick(m_valid, (mdl_last + 1) % N);
`else
    w = pick(m_valid, 0);
`endif
    if (reset) begin
      mdl_busy  <= 1'b0;
      mdl_grant <= 0;
`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
      mdl_last  <= N - 1;
`endif
    end else if (!mdl_busy) begin
      if (w >= 0) begin
        mdl_busy  <= 1'b1;
        mdl_grant <= w;
      end
    end else if (m_valid[mdl_grant] !== 1'b1) begin
      mdl_busy <= 1'b0;
    end else if (s_ready) begin
      mdl_busy <= 1'b0;
`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
      mdl_last <= mdl_grant;
`endif
    end
  end

  always_comb begin
    exp_o = '0;
    if (mdl_busy) begin
      exp_o.sv             = m_valid[mdl_grant];
      exp_o.addr           = m_addr[mdl_grant*AW +: AW];
      exp_o.wdata          = m_wdata[mdl_grant*DW +: DW];
      exp_o.wstrb          = m_wstrb[mdl_grant*SW +: SW];
      exp_o.rdy[mdl_grant] = s_ready & m_valid[mdl_grant];
      exp_o.rdata          = s_rdata;
    end
  end

  task automatic set_master(input int i, input logic v, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_valid[i]         = v;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = d;
    m_wstrb[i*SW +: SW] = s;
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    to_drive();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    s_ready = 1'b1;
    s_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < N; i++) set_master(i, 1'b1, $urandom(), $urandom(), 4'hF);
    to_drive();
    for (int c = 0; c < 2; c++) begin
      to_sample();
      checks++;
      if (act !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected 0", act);
      end
      to_drive();
    end
    reset   = 1'b0;
    m_valid = '0;
    s_ready = 1'b0;
  endtask

  task automatic test_single_read();
    set_master(1, 1'b1, 32'h100, 32'h0, 4'h0);
    s_ready = 1'b1;
    s_rdata = 32'hDEAD_BEEF;
    to_sample();
    checks++;
    if (s_valid !== 1'b0 || m_ready !== 3'b000) begin
      errors++;
      $display("FAIL read_idle_cycle: got s_valid=%b m_ready=%b expected 0/000", s_valid, m_ready);
    end
    to_drive();
    to_sample();
    checks++;
    if (s_valid !== 1'b1 || s_addr !== 32'h100 || s_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL read_slave_req: got v=%b addr=%h strb=%h expected 1/100/0", s_valid, s_addr, s_wstrb);
    end
    checks++;
    if (m_ready !== 3'b010 || m_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_complete: got ready=%b rdata=%h expected 010/deadbeef", m_ready, m_rdata);
    end
    to_drive();
    m_valid = '0;
    s_ready = 1'b0;
  endtask

  task automatic test_write_wait();
    set_master(2, 1'b1, 32'h20, 32'h1234_5678, 4'b0011);
    s_ready = 1'b0;
    to_sample();
    to_drive();
    for (int k = 1; k <= 4; k++) begin
      s_ready = (k == 4);
      to_sample();
      checks++;
      if (s_valid !== 1'b1 || s_addr !== 32'h20 || s_wdata !== 32'h1234_5678 || s_wstrb !== 4'b0011) begin
        errors++;
        $display("FAIL write_fields_c%0d: got v=%b addr=%h data=%h strb=%b expected 1/20/12345678/0011",
                 k, s_valid, s_addr, s_wdata, s_wstrb);
      end
      checks++;
      if (m_ready !== ((k == 4) ? 3'b100 : 3'b000)) begin
        errors++;
        $display("FAIL write_ready_c%0d: got %b expected %b", k, m_ready, (k == 4) ? 3'b100 : 3'b000);
      end
      to_drive();
    end
    m_valid = '0;
    s_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    int order_n;
    int idx;
    int exp_idx;
    int exp_cnt;
    int cnt[N];
    pulse_reset();
    s_ready = 1'b1;
    for (int i = 0; i < N; i++) set_master(i, 1'b1, 32'h1000 + 32'(i * 16), 32'(i), 4'h0);
    order_n = 0;
    cnt     = '{default: 0};
    for (int c = 0; c < 18; c++) begin
      to_sample();
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL rr_model_c%0d: got %h expected %h", c, act, exp_o);
      end
      checks++;
      if ((m_ready != '0) !== (c % 2 == 1)) begin
        errors++;
        $display("FAIL rr_spacing_c%0d: got ready=%b expected completion only on odd cycles", c, m_ready);
      end
      idx = -1;
      for (int i = 0; i < N; i++) if (m_ready[i]) idx = i;
      if (idx >= 0) begin
        cnt[idx]++;
`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
        exp_idx = order_n % N;
`else
        exp_idx = 0;
`endif
        checks++;
        if (idx != exp_idx) begin
          errors++;
          $display("FAIL rr_order_%0d: got master %0d expected %0d", order_n, idx, exp_idx);
        end
        order_n++;
      end
      to_drive();
      if (idx >= 0) m_addr[idx*AW +: AW] = m_addr[idx*AW +: AW] + 32'h4;
    end
    for (int i = 0; i < N; i++) begin
`ifdef VIGNA_BUS_ARB_ROUND_ROBIN_EN
      exp_cnt = 3;
`else
      exp_cnt = (i == 0) ? 9 : 0;
`endif
      checks++;
      if (cnt[i] != exp_cnt) begin
        errors++;
        $display("FAIL rr_count_m%0d: got %0d expected %0d", i, cnt[i], exp_cnt);
      end
    end
    m_valid = '0;
  endtask

  task automatic test_reset_busy();
    m_valid = '0;
    s_ready = 1'b1;
    s_rdata = 32'h5555_AAAA;
    set_master(1, 1'b1, 32'h44, 32'h0, 4'h0);
    to_sample();
    to_drive();
    to_sample();
    checks++;
    if (m_ready !== 3'b010) begin
      errors++;
      $display("FAIL rb_first_m1: got %b expected 010", m_ready);
    end
    to_drive();
    s_ready = 1'b0;
    to_sample();
    to_drive();
    to_sample();
    checks++;
    if (s_valid !== 1'b1 || m_ready !== 3'b000) begin
      errors++;
      $display("FAIL rb_stalled: got v=%b ready=%b expected 1/000", s_valid, m_ready);
    end
    to_drive();
    reset = 1'b1;
    to_sample();
    to_drive();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_master(i, 1'b1, 32'h200 + 32'(i), 32'h0, 4'h0);
    s_ready = 1'b1;
    to_sample();
    checks++;
    if (s_valid !== 1'b0 || m_ready !== 3'b000 || s_addr !== '0 || m_rdata !== '0) begin
      errors++;
      $display("FAIL rb_after_reset: got v=%b ready=%b addr=%h rdata=%h expected all zero",
               s_valid, m_ready, s_addr, m_rdata);
    end
    to_drive();
    to_sample();
    checks++;
    if (m_ready !== 3'b001 || s_addr !== 32'h200) begin
      errors++;
      $display("FAIL rb_m0_first: got ready=%b addr=%h expected 001/200", m_ready, s_addr);
    end
    to_drive();
    m_valid = '0;
    s_ready = 1'b0;
  endtask

  task automatic test_withdraw();
    pulse_reset();
    s_ready = 1'b0;
    set_master(0, 1'b1, 32'hA0, 32'h0, 4'h0);
    set_master(1, 1'b1, 32'hB0, 32'h0, 4'h0);
    to_sample();
    to_drive();
    to_sample();
    checks++;
    if (s_valid !== 1'b1 || s_addr !== 32'hA0) begin
      errors++;
      $display("FAIL wd_grant_m0: got v=%b addr=%h expected 1/a0", s_valid, s_addr);
    end
    to_drive();
    m_valid[0] = 1'b0;
    to_sample();
    checks++;
    if (s_valid !== 1'b0 || m_ready !== 3'b000) begin
      errors++;
      $display("FAIL wd_drop: got v=%b ready=%b expected 0/000", s_valid, m_ready);
    end
    to_drive();
    to_sample();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL wd_idle: got v=%b expected 0", s_valid);
    end
    to_drive();
    s_ready = 1'b1;
    to_sample();
    checks++;
    if (s_valid !== 1'b1 || s_addr !== 32'hB0 || m_ready !== 3'b010) begin
      errors++;
      $display("FAIL wd_grant_m1: got v=%b addr=%h ready=%b expected 1/b0/010", s_valid, s_addr, m_ready);
    end
    to_drive();
    m_valid = '0;
    s_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] rdy;
    int done_total;
    done_total = 0;
    m_valid    = '0;
    for (int c = 0; c < 500; c++) begin
      s_ready = ($urandom_range(0, 2) != 0);
      s_rdata = $urandom();
      for (int i = 0; i < N; i++) begin
        if (!m_valid[i] && $urandom_range(0, 1) == 1)
          set_master(i, 1'b1, $urandom(), $urandom(),
                     ($urandom_range(0, 1) == 1) ? SW'($urandom()) : '0);
      end
      to_sample();
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL random_model_c%0d: got %h expected %h", c, act, exp_o);
      end
      checks++;
      if ($countones(m_ready) > 1) begin
        errors++;
        $display("FAIL random_onehot_c%0d: got %b expected at most one bit", c, m_ready);
      end
      rdy = m_ready;
      to_drive();
      for (int i = 0; i < N; i++) begin
        if (rdy[i]) begin
          done_total++;
          m_valid[i] = 1'b0;
        end
      end
    end
    checks++;
    if (done_total < 20) begin
      errors++;
      $display("FAIL random_progress: got %0d completions expected at least 20", done_total);
    end
    m_valid = '0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    m_valid = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    test_reset();
    test_single_read();
    test_write_wait();
    test_round_robin();
    test_reset_busy();
    test_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
